// File: rtl/pong_sequencer_if.sv
// Signal bundle between the Pong game-flow controller and its surroundings:
// the pulse inputs from buttons, frame tick and ball datapath, plus all controller outputs.
interface pong_if;
    logic       frame;
    logic       fire;
    logic       hit;
    logic       coll_l;
    logic       coll_r;
    logic [2:0] state;
    logic       pos_load;
    logic       play_en;
    logic       serve_dir;
    logic [2:0] speed_lvl;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;

    modport master (
        output frame, fire, hit, coll_l, coll_r,
        input  state, pos_load, play_en, serve_dir, speed_lvl, score_l, score_r, winner
    );

    modport slave (
        input  frame, fire, hit, coll_l, coll_r,
        output state, pos_load, play_en, serve_dir, speed_lvl, score_l, score_r, winner
    );
endinterface

// File: rtl/pong_sequencer.sv
// Pong game-flow controller: sequences serve, play, point and game-over phases and owns
// scores, serve direction and ball speed level. Every output is a register.
module pong_sequencer #(
    parameter int unsigned WIN          = 4,
    parameter int unsigned SPEEDUP      = 5,
    parameter int unsigned MAX_LVL      = 4,
    parameter int unsigned SERVE_FRAMES = 180
) (
    input logic  clk_pix,
    input logic  rst_pix,
    pong_if.slave bus
);

    typedef enum logic [2:0] {
        NewGame  = 3'd0,
        Position = 3'd1,
        Ready    = 3'd2,
        Play     = 3'd3,
        Paused   = 3'd4,
        Point    = 3'd5,
        EndGame  = 3'd6
    } state_e;

    localparam logic [3:0] WinScore  = 4'(WIN);
    localparam logic [3:0] ShotLast  = 4'(SPEEDUP - 1);
    localparam logic [2:0] LvlMax    = 3'(MAX_LVL);
    localparam logic [7:0] WaitLast  = 8'(SERVE_FRAMES - 1);
    localparam bit         AutoServe = (SERVE_FRAMES != 0);

    state_e     st;
    logic       pos_load;
    logic       play_en;
    logic       serve_dir;
    logic [2:0] speed_lvl;
    logic [3:0] shot_cnt;
    logic [7:0] wait_cnt;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;

    logic       coll;
    logic       timeout;
    logic [3:0] new_l;
    logic [3:0] new_r;

    assign coll    = bus.coll_l | bus.coll_r;
    assign timeout = bus.frame && AutoServe && (wait_cnt == WaitLast);
    // Scores after this cycle's collisions; game-over is judged on these.
    assign new_l   = score_l + {3'd0, bus.coll_r};
    assign new_r   = score_r + {3'd0, bus.coll_l};

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            st        <= NewGame;
            pos_load  <= 1'b0;
            play_en   <= 1'b0;
            serve_dir <= 1'b0;
            speed_lvl <= 3'd0;
            shot_cnt  <= 4'd0;
            wait_cnt  <= 8'd0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            winner    <= 2'b00;
        end else begin
            unique case (st)
                NewGame: begin
                    st        <= Position;
                    pos_load  <= 1'b1;
                    speed_lvl <= 3'd0;
                    shot_cnt  <= 4'd0;
                    wait_cnt  <= 8'd0;
                end
                Position: begin
                    st       <= Ready;
                    pos_load <= 1'b0;
                end
                Ready: begin
                    if (bus.fire || timeout) begin
                        st       <= Play;
                        play_en  <= 1'b1;
                        wait_cnt <= 8'd0;
                    end else if (bus.frame && wait_cnt != 8'hff) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                Play: begin
                    if (coll) begin
                        score_l  <= new_l;
                        score_r  <= new_r;
                        play_en  <= 1'b0;
                        wait_cnt <= 8'd0;
                        if (bus.coll_r && !bus.coll_l) begin
                            serve_dir <= 1'b1;
                        end else if (bus.coll_l && !bus.coll_r) begin
                            serve_dir <= 1'b0;
                        end
                        if (new_l == WinScore || new_r == WinScore) begin
                            st     <= EndGame;
                            winner <= {new_r == WinScore, new_l == WinScore};
                        end else begin
                            st <= Point;
                        end
                    end else if (bus.fire) begin
                        st      <= Paused;
                        play_en <= 1'b0;
                    end else if (bus.hit) begin
                        if (shot_cnt == ShotLast) begin
                            shot_cnt <= 4'd0;
                            if (speed_lvl < LvlMax) speed_lvl <= speed_lvl + 3'd1;
                        end else begin
                            shot_cnt <= shot_cnt + 4'd1;
                        end
                    end
                end
                Paused: begin
                    if (bus.fire) begin
                        st      <= Play;
                        play_en <= 1'b1;
                    end
                end
                Point: begin
                    if (bus.fire || timeout) begin
                        st        <= Position;
                        pos_load  <= 1'b1;
                        speed_lvl <= 3'd0;
                        shot_cnt  <= 4'd0;
                        wait_cnt  <= 8'd0;
                    end else if (bus.frame && wait_cnt != 8'hff) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                EndGame: begin
                    // Clear on exit so NEW_GAME already shows a blank scoreboard.
                    if (bus.fire) begin
                        st        <= NewGame;
                        winner    <= 2'b00;
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        serve_dir <= 1'b0;
                    end
                end
                default: st <= NewGame;
            endcase
        end
    end

    assign bus.state     = st;
    assign bus.pos_load  = pos_load;
    assign bus.play_en   = play_en;
    assign bus.serve_dir = serve_dir;
    assign bus.speed_lvl = speed_lvl;
    assign bus.score_l   = score_l;
    assign bus.score_r   = score_r;
    assign bus.winner    = winner;

endmodule

// File: tb/tb_pong_sequencer.sv
// Bench for pong_sequencer: directed scenarios plus a random soak, all checked against
// an abstract game model (scores, total hits per rally, frames waited).
module tb_pong_sequencer;
    localparam int WIN = 4, SPEEDUP = 5, MAX_LVL = 4, SERVE_FRAMES = 3;
    localparam int S_NEW = 0, S_POS = 1, S_READY = 2, S_PLAY = 3;
    localparam int S_PAUSE = 4, S_POINT = 5, S_END = 6;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    pong_if pif ();

    pong_sequencer #(
        .WIN(WIN), .SPEEDUP(SPEEDUP), .MAX_LVL(MAX_LVL), .SERVE_FRAMES(SERVE_FRAMES)
    ) dut (
        .clk_pix(clk_pix),
        .rst_pix(rst_pix),
        .bus(pif)
    );

    always #5 clk_pix = ~clk_pix;

    int checks = 0;
    int errors = 0;

    // Abstract model: speed level is derived from the rally's total hit count.
    int m_state, m_sl, m_sr, m_dir, m_hits, m_wait;

    function automatic int m_lvl();
        int l = m_hits / SPEEDUP;
        return (l > MAX_LVL) ? MAX_LVL : l;
    endfunction

    function automatic int m_winner();
        if (m_state != S_END) return 0;
        return ((m_sr == WIN) ? 2 : 0) + ((m_sl == WIN) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_state = S_NEW; m_sl = 0; m_sr = 0; m_dir = 0; m_hits = 0; m_wait = 0;
    endtask

    task automatic model_step(input bit fr, input bit fi, input bit h, input bit cl,
                              input bit cr);
        int nxt = m_state;
        case (m_state)
            S_NEW: nxt = S_POS;
            S_POS: nxt = S_READY;
            S_READY, S_POINT: begin
                if (fi || (fr && SERVE_FRAMES != 0 && m_wait == SERVE_FRAMES - 1))
                    nxt = (m_state == S_READY) ? S_PLAY : S_POS;
                else if (fr && m_wait < 255)
                    m_wait++;
            end
            S_PLAY: begin
                if (cl || cr) begin
                    m_sl += int'(cr);
                    m_sr += int'(cl);
                    if (cr && !cl) m_dir = 1;
                    else if (cl && !cr) m_dir = 0;
                    nxt = (m_sl == WIN || m_sr == WIN) ? S_END : S_POINT;
                end else if (fi) begin
                    nxt = S_PAUSE;
                end else if (h) begin
                    m_hits++;
                end
            end
            S_PAUSE: if (fi) nxt = S_PLAY;
            S_END:   if (fi) nxt = S_NEW;
            default: ;
        endcase
        if (nxt != m_state) begin
            m_wait = 0;
            if (nxt == S_NEW) begin m_sl = 0; m_sr = 0; m_dir = 0; end
            if (nxt == S_POS) m_hits = 0;
        end
        m_state = nxt;
    endtask

    task automatic step(input bit fr, input bit fi, input bit h, input bit cl, input bit cr);
        pif.frame = fr; pif.fire = fi; pif.hit = h; pif.coll_l = cl; pif.coll_r = cr;
        @(posedge clk_pix);
        model_step(fr, fi, h, cl, cr);
        #1;
        pif.frame = 0; pif.fire = 0; pif.hit = 0; pif.coll_l = 0; pif.coll_r = 0;
    endtask

    task automatic do_reset();
        rst_pix = 1'b1;
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;
        model_reset();
    endtask

    task automatic to_play();
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
    endtask

    // Score one point from PLAY and come back to PLAY through POINT/POSITION/READY.
    task automatic score_and_reserve(input bit cl, input bit cr);
        step(0, 0, 0, cl, cr);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        pif.frame = 0; pif.fire = 0; pif.hit = 0; pif.coll_l = 0; pif.coll_r = 0;
        rst_pix = 1'b1;
        #23;
        checks++;
        if ({pif.state, pif.pos_load, pif.play_en, pif.serve_dir, pif.speed_lvl, pif.score_l,
             pif.score_r, pif.winner} !== 19'd0) begin
            errors++;
            $display("FAIL reset_values state=%0d pos_load=%0b play_en=%0b scores=%0d/%0d exp all 0",
                     pif.state, pif.pos_load, pif.play_en, pif.score_l, pif.score_r);
        end
        @(posedge clk_pix); #1;
        rst_pix = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0);
        checks++;
        if (pif.state !== 3'd1 || pif.pos_load !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_position state=%0d pos_load=%0b exp 1/1", pif.state, pif.pos_load);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (pif.state !== 3'd2 || pif.pos_load !== 1'b0 || pif.score_l !== 4'd0
            || pif.score_r !== 4'd0) begin
            errors++;
            $display("FAIL reset_to_ready state=%0d pos_load=%0b scores=%0d/%0d exp 2/0 0/0",
                     pif.state, pif.pos_load, pif.score_l, pif.score_r);
        end
        repeat ($urandom_range(2, 6)) step(0, 0, 0, 0, 0);
        checks++;
        if (pif.state !== 3'd2) begin
            errors++;
            $display("FAIL ready_hold state=%0d exp 2", pif.state);
        end
    endtask

    task automatic test_serve();
        to_play();
        checks++;
        if (pif.state !== 3'd3 || pif.play_en !== 1'b1) begin
            errors++;
            $display("FAIL serve_fire state=%0d play_en=%0b exp 3/1", pif.state, pif.play_en);
        end
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int f = 0; f < SERVE_FRAMES; f++) begin
            repeat ($urandom_range(0, 4)) step(0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
            checks++;
            if (pif.state !== ((f == SERVE_FRAMES - 1) ? 3'd3 : 3'd2)
                || pif.play_en !== (f == SERVE_FRAMES - 1)) begin
                errors++;
                $display("FAIL auto_serve frame=%0d state=%0d play_en=%0b", f + 1, pif.state,
                         pif.play_en);
            end
        end
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        checks++;
        if (pif.state !== 3'd3) begin
            errors++;
            $display("FAIL fire_and_timeout state=%0d exp 3", pif.state);
        end
    endtask

    task automatic test_speedup();
        to_play();
        for (int i = 1; i <= 30; i++) begin
            repeat ($urandom_range(0, 2)) step($urandom_range(0, 1) == 1, 0, 0, 0, 0);
            step(0, 0, 1, 0, 0);
            checks++;
            if (int'(pif.speed_lvl) != ((i / 5 > 4) ? 4 : i / 5)) begin
                errors++;
                $display("FAIL speed_lvl hits=%0d got=%0d exp=%0d", i, pif.speed_lvl,
                         (i / 5 > 4) ? 4 : i / 5);
            end
        end
    endtask

    task automatic test_point();
        to_play();
        repeat (9) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        checks++;
        if (pif.state !== 3'd5 || pif.score_l !== 4'd1 || pif.score_r !== 4'd0
            || pif.serve_dir !== 1'b1 || pif.play_en !== 1'b0 || pif.speed_lvl !== 3'd1) begin
            errors++;
            $display("FAIL point_coll_r state=%0d score=%0d/%0d dir=%0b speed=%0d exp 5 1/0 1 1",
                     pif.state, pif.score_l, pif.score_r, pif.serve_dir, pif.speed_lvl);
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if (pif.state !== 3'd1 || pif.pos_load !== 1'b1 || pif.speed_lvl !== 3'd0) begin
            errors++;
            $display("FAIL point_fire state=%0d pos_load=%0b speed=%0d exp 1/1/0", pif.state,
                     pif.pos_load, pif.speed_lvl);
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        checks++;
        if (pif.state !== 3'd5 || pif.score_r !== 4'd1 || pif.serve_dir !== 1'b0) begin
            errors++;
            $display("FAIL point_coll_l state=%0d score_r=%0d dir=%0b exp 5/1/0", pif.state,
                     pif.score_r, pif.serve_dir);
        end
        for (int f = 0; f < SERVE_FRAMES; f++) begin
            repeat ($urandom_range(0, 3)) step(0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        checks++;
        if (pif.state !== 3'd1 || pif.pos_load !== 1'b1) begin
            errors++;
            $display("FAIL point_timeout state=%0d pos_load=%0b exp 1/1", pif.state, pif.pos_load);
        end
    endtask

    task automatic test_tie();
        to_play();
        for (int k = 0; k < 3; k++) begin
            score_and_reserve(1, 0);
            score_and_reserve(0, 1);
        end
        checks++;
        if (pif.state !== 3'd3 || pif.score_l !== 4'd3 || pif.score_r !== 4'd3) begin
            errors++;
            $display("FAIL tie_setup state=%0d score=%0d/%0d exp 3 3/3", pif.state, pif.score_l,
                     pif.score_r);
        end
        step(0, 0, 1, 1, 1);
        checks++;
        if (pif.state !== 3'd6 || pif.score_l !== 4'd4 || pif.score_r !== 4'd4
            || pif.winner !== 2'b11 || pif.serve_dir !== 1'b1) begin
            errors++;
            $display("FAIL tie_end state=%0d score=%0d/%0d winner=%b dir=%0b exp 6 4/4 11 1",
                     pif.state, pif.score_l, pif.score_r, pif.winner, pif.serve_dir);
        end
        step(1, 0, 1, 1, 1);
        checks++;
        if (pif.state !== 3'd6 || pif.score_l !== 4'd4 || pif.winner !== 2'b11) begin
            errors++;
            $display("FAIL end_hold state=%0d score_l=%0d winner=%b exp 6/4/11", pif.state,
                     pif.score_l, pif.winner);
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if (pif.state !== 3'd0 || pif.winner !== 2'b00 || pif.score_l !== 4'd0
            || pif.score_r !== 4'd0) begin
            errors++;
            $display("FAIL end_fire state=%0d winner=%b score=%0d/%0d exp 0 00 0/0", pif.state,
                     pif.winner, pif.score_l, pif.score_r);
        end
    endtask

    task automatic test_pause_reset();
        to_play();
        repeat (5) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        checks++;
        if (pif.state !== 3'd4 || pif.play_en !== 1'b0) begin
            errors++;
            $display("FAIL pause state=%0d play_en=%0b exp 4/0", pif.state, pif.play_en);
        end
        step(0, 0, 0, 1, 0);
        repeat (5) step(0, 0, 1, 0, 0);
        checks++;
        if (pif.state !== 3'd4 || pif.score_r !== 4'd0 || pif.speed_lvl !== 3'd1) begin
            errors++;
            $display("FAIL pause_ignore state=%0d score_r=%0d speed=%0d exp 4/0/1", pif.state,
                     pif.score_r, pif.speed_lvl);
        end
        step(0, 1, 0, 0, 0);
        score_and_reserve(0, 1);
        repeat (5) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        @(negedge clk_pix);
        rst_pix = 1'b1;
        #1;
        checks++;
        if ({pif.state, pif.pos_load, pif.play_en, pif.serve_dir, pif.speed_lvl, pif.score_l,
             pif.score_r, pif.winner} !== 19'd0) begin
            errors++;
            $display("FAIL reset_in_pause state=%0d dir=%0b speed=%0d score_l=%0d exp all 0",
                     pif.state, pif.serve_dir, pif.speed_lvl, pif.score_l);
        end
        @(posedge clk_pix); #1;
        rst_pix = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [18:0] exp_v;
        logic [18:0] act_v;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0);
            exp_v = {3'(m_state), m_state == S_POS, m_state == S_PLAY, 1'(m_dir), 3'(m_lvl()),
                     4'(m_sl), 4'(m_sr), 2'(m_winner())};
            act_v = {pif.state, pif.pos_load, pif.play_en, pif.serve_dir, pif.speed_lvl,
                     pif.score_l, pif.score_r, pif.winner};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random cycle=%0d got=%h exp=%h", c, act_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_speedup();
        test_point();
        test_tie();
        test_pause_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
